// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// requester ids, reset winner, default width and the slot state encoding.
// The optional ARB_LOCK_EN build macro is handled in mux_rr_arbiter.sv.
package mux_rr_arbiter_pkg;

  localparam logic REQ0          = 1'b0;
  localparam logic REQ1          = 1'b1;
  localparam logic RST_LAST_GNT  = 1'b1;
  localparam int   DEFAULT_WIDTH = 8;

  // State = {slot full, last winner}; the bit layout is relied on by the top.
  typedef enum logic [1:0] {
    ST_EMPTY_G0 = 2'b00,
    ST_EMPTY_G1 = 2'b01,
    ST_FULL_G0  = 2'b10,
    ST_FULL_G1  = 2'b11
  } arb_state_e;

  // Plain round-robin pick: a lone requester wins, contention goes to the
  // requester that did not win last, idle keeps the previous winner.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    logic pick;
    if (v0 && !v1) begin
      pick = REQ0;
    end else if (!v0 && v1) begin
      pick = REQ1;
    end else if (v0 && v1) begin
      pick = ~last;
    end else begin
      pick = last;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux2_w.sv
// WIDTH-wide 2:1 multiplexer: y = s ? d1 : d0.
module mux2_w
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output slot.
// A slot can drain and refill in the same cycle; a full, stalled slot blocks
// both requesters. Build macro ARB_LOCK_EN lets the last winner hold the grant
// while its lock input is high; without it lock0/lock1 are ignored.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid0,
  input  logic [WIDTH-1:0] in_data0,
  output logic             in_ready0,
  input  logic             in_valid1,
  input  logic [WIDTH-1:0] in_data1,
  output logic             in_ready1,
  input  logic             lock0,
  input  logic             lock1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             last_gnt
);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_mux_y;
  logic             w_full;
  logic             w_last;
  logic             w_slot_free;
  logic             w_sel_rr;
  logic             w_sel;
  logic             w_accept;

  assign w_full      = r_state[1];
  assign w_last      = r_state[0];
  assign w_slot_free = !w_full || out_ready;
  assign w_sel_rr    = rr_pick(in_valid0, in_valid1, w_last);

`ifdef ARB_LOCK_EN
  logic w_lock_last;
  logic w_valid_last;
  assign w_lock_last  = w_last ? lock1 : lock0;
  assign w_valid_last = w_last ? in_valid1 : in_valid0;
  // A lock only counts for the requester that won last and is still valid.
  assign w_sel = (w_lock_last && w_valid_last) ? w_last : w_sel_rr;
`else
  logic w_unused_lock;
  assign w_unused_lock = lock0 | lock1;
  assign w_sel = w_sel_rr;
`endif

  assign in_ready0 = !rst && w_slot_free && in_valid0 && (w_sel == REQ0);
  assign in_ready1 = !rst && w_slot_free && in_valid1 && (w_sel == REQ1);
  assign w_accept  = in_ready0 || in_ready1;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .s  (w_sel),
    .d0 (in_data0),
    .d1 (in_data1),
    .y  (w_mux_y)
  );

  // Slot state register; reset empties the slot and favours requester 0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= arb_state_e'({1'b0, RST_LAST_GNT});
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next slot state: accept fills and records the winner, drain empties.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY_G0, ST_EMPTY_G1: begin
        if (w_accept) begin
          w_state_next = arb_state_e'({1'b1, w_sel});
        end else begin
          w_state_next = r_state;
        end
      end
      ST_FULL_G0, ST_FULL_G1: begin
        if (w_accept) begin
          w_state_next = arb_state_e'({1'b1, w_sel});
        end else if (out_ready) begin
          w_state_next = arb_state_e'({1'b0, w_last});
        end else begin
          w_state_next = r_state;
        end
      end
      default: begin
        w_state_next = arb_state_e'({1'b0, RST_LAST_GNT});
      end
    endcase
  end

  // Output data register; loads the selected word on accept, else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_out_data <= w_mux_y;
    end else begin
      r_out_data <= r_out_data;
    end
  end

  assign sel       = w_sel;
  assign out_valid = w_full;
  assign last_gnt  = w_last;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a random
// phase, all compared against a cycle-level reference model of the slot.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid0, in_valid1;
  logic [7:0] in_data0, in_data1;
  logic       in_ready0, in_ready1;
  logic       lock0, lock1;
  logic       sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       last_gnt;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_last  = 1'b1;
  logic       obs_rdy0, obs_rdy1;
  logic [7:0] seq [4];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid0 (in_valid0),
    .in_data0  (in_data0),
    .in_ready0 (in_ready0),
    .in_valid1 (in_valid1),
    .in_data1  (in_data1),
    .in_ready1 (in_ready1),
    .lock0     (lock0),
    .lock1     (lock1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .last_gnt  (last_gnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model predicts handshakes and the slot.
  task automatic step(input logic r, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1,
                      input logic l0, input logic l1, input logic ordy);
    logic v [2];
    logic l [2];
    logic [7:0] d [2];
    int   winner;
    logic acc;
    @(negedge clk);
    rst = r; in_valid0 = v0; in_data0 = d0; in_valid1 = v1; in_data1 = d1;
    lock0 = l0; lock1 = l1; out_ready = ordy;
    v[0] = v0; v[1] = v1; l[0] = l0; l[1] = l1; d[0] = d0; d[1] = d1;
    #1;
    // who would get the slot: lone requester, else the one that waited
    if (v[0] && v[1]) winner = (m_last == 1'b1) ? 0 : 1;
    else if (v[0])    winner = 0;
    else if (v[1])    winner = 1;
    else              winner = int'(m_last);
`ifdef ARB_LOCK_EN
    if (l[int'(m_last)] && v[int'(m_last)]) winner = int'(m_last);
`endif
    acc = !r && (!m_valid || ordy) && v[winner];
    obs_rdy0 = in_ready0;
    obs_rdy1 = in_ready1;
    chk("in_ready0", in_ready0, acc && (winner == 0));
    chk("in_ready1", in_ready1, acc && (winner == 1));
    if (!r) chk("sel", sel, winner);
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_data = 8'h00; m_last = 1'b1;
    end else if (acc) begin
      m_valid = 1'b1; m_data = d[winner]; m_last = (winner == 1);
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("last_gnt", last_gnt, m_last);
  endtask

  initial begin
    rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; in_data0 = 8'h00; in_data1 = 8'h00;
    lock0 = 1'b0; lock1 = 1'b0; out_ready = 1'b0;

    // reset held 2 cycles with both requesters valid
    step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    chk("rst_rdy0", obs_rdy0, 1'b0);
    chk("rst_rdy1", obs_rdy1, 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", last_gnt, 1'b1);

    // single requester
    step(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("single_rdy0", obs_rdy0, 1'b1);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 8'hA5);
    chk("single_last", last_gnt, 1'b0);

    // contention from a fresh reset: 11,22,11,22
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
      seq[i] = out_data;
    end
    chk("cont0", seq[0], 8'h11);
    chk("cont1", seq[1], 8'h22);
    chk("cont2", seq[2], 8'h11);
    chk("cont3", seq[3], 8'h22);

    // backpressure: fill, stall 3 cycles, then drain+refill together
    step(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      chk("bp_rdy0", obs_rdy0, 1'b0);
      chk("bp_rdy1", obs_rdy1, 1'b0);
      chk("bp_data", out_data, 8'h5A);
    end
    step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("refill_rdy1", obs_rdy1, 1'b1);
    chk("refill_valid", out_valid, 1'b1);
    chk("refill_data", out_data, 8'h22);

    // reset mid-operation drops a full slot
    step(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("mid_fill", out_data, 8'h33);
    step(1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_last", last_gnt, 1'b1);
    chk("mid_data", out_data, 8'h00);

    // lock0 held for 3 accepts, then dropped
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
      seq[i] = out_data;
    end
    step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    seq[3] = out_data;
`ifdef ARB_LOCK_EN
    chk("lock0", seq[0], 8'h11);
    chk("lock1", seq[1], 8'h11);
    chk("lock2", seq[2], 8'h11);
    chk("lock_drop", seq[3], 8'h22);
`else
    chk("nolock0", seq[0], 8'h11);
    chk("nolock1", seq[1], 8'h22);
    chk("nolock2", seq[2], 8'h11);
    chk("nolock3", seq[3], 8'h22);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom),
           1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
